display_scan_mux: RTL and testbench
===================================

// Module: display_scan_mux
// PURPOSE
//  Time-multiplexes a 4*NDIG-bit hex value onto a common-segment display.
//  Each refresh slot selects one digit, presents its nibble on I for the
//  downstream hex-to-7-segment decoder, and drives the active-low anodes.
//  A new value takes effect only at a frame boundary, so a half-updated
//  frame never appears. Optional leading-zero blanking is included.
// PARAMETERS
//  NDIG     4      digits scanned (>=2); D width = 4*NDIG
//  DIV_W    16     refresh divider width
//  DIV_MAX  49999  divider terminal count; slot length = DIV_MAX+1 clks
// PORTS
//  clk      in   1        system clock, all state on rising edge
//  rst      in   1        synchronous, active-high reset
//  load     in   1        capture D into pending register this cycle
//  D        in   4*NDIG   value to display; digit k = D[4k+3:4k], k=0 LSD
//  DP_IN    in   NDIG     decimal point request per digit, active-high
//  LZ_EN    in   1        1 = blank leading zero digits
//  I        out  4        nibble of current digit, to segment decoder
//  AN       out  NDIG     anode enables, active-low, at most one bit low
//  DP       out  1        decimal point for current digit, active-low
//  FRAME    out  1        1-clk pulse when slot NDIG-1 wraps to slot 0
// BEHAVIOUR
//  State: div[DIV_W-1:0], idx (0..NDIG-1), shadow, pending, pend flag.
//  Reset (rst=1 at edge): div=0, idx=0, shadow=0, pending=0, pend=0,
//   FRAME=0. Outputs after reset: I=0000, AN=~1 (only bit0 low), DP=1.
//  Divider: tick = (div==DIV_MAX). On tick div<=0, else div<=div+1.
//  Scan: on tick idx<=idx+1; idx==NDIG-1 wraps to 0 (the wrap).
//  I, AN, DP decoded combinationally from registered idx/shadow/DP_IN:
//   I = shadow[4*idx+3:4*idx]; AN = all 1 except bit idx = 0;
//   DP = ~DP_IN[idx] (DP_IN is live, not shadowed).
//  Load: load=1 -> pending<=D, pend<=1. Repeated loads overwrite pending;
//   last one before the wrap wins.
//  Transfer: on the wrap edge, if pend: shadow<=pending, pend<=0.
//   Slot 0 of the new frame is the first to show the new value.
//  load and wrap in the same cycle: shadow<=old pending (if pend),
//   pending<=D, pend stays 1; new D shown from the following frame.
//  FRAME: registered; high for exactly the clk after each wrap edge.
//  Leading-zero blanking: digit idx is blank if LZ_EN=1, idx!=0, and
//   shadow nibbles idx..NDIG-1 are all zero. Blank slot: AN all 1, DP=1,
//   I still shows the nibble. Digit 0 is never blanked (0 shows "0").
//  LZ_EN and DP_IN changes act immediately on the current slot.
//  rst mid-frame: same as power-up reset; pending load is discarded.
//  No arithmetic beyond divider increment; no overflow conditions exist.
// TESTING (NDIG=4, DIV_MAX=3 in bench)
//  1 Reset: rst 2 clks -> I=0, AN=1110, DP=1, FRAME=0, idx=0 for 4 clks.
//  2 Scan: load D=16'h1234 in slot 2, run 2 frames -> first frame all 0;
//    second frame I=4,3,2,1 with AN=1110,1101,1011,0111, 4 clks each,
//    FRAME pulse once per 16 clks.
//  3 No tearing: load 16'hABCD then 16'h5678 within one frame -> only
//    5678 appears, from slot 0 of next frame; ABCD never displayed.
//  4 LZ: shadow=16'h0050, LZ_EN=1 -> AN=1110,1101,1111,1111; value 0000
//    -> only slot 0 lit with I=0; LZ_EN=0 -> all four lit.
//  5 Collision: load 16'h1111 on the wrap edge while pending=16'h2222 ->
//    next frame shows 2222, following frame shows 1111.
//  6 rst mid-frame in slot 2 with pend=1 -> outputs as test 1, pend
//    cleared, no value transferred at next wrap.

Source files
------------

// File: rtl/display_scan_mux.sv
// display_scan_mux
//
// Purpose:
//   Time-multiplexes a 4*NDIG-bit hex value onto a common-segment display.
//   A free-running divider defines refresh slots of DIV_MAX+1 clocks; each
//   slot selects one digit, presents its nibble on I for a downstream
//   hex-to-7-segment decoder and pulls that digit's anode low. New values
//   are staged in a pending register and only copied into the displayed
//   (shadow) register when the scan wraps from the last digit back to
//   digit 0, so a frame is never shown half-updated. Optional leading-zero
//   blanking suppresses zero digits above the most significant non-zero one.
//
// Ports:
//   clk    in   1        system clock, all state on rising edge
//   rst    in   1        synchronous, active-high reset
//   load   in   1        capture D into the pending register this cycle
//   D      in   4*NDIG   value to display, digit k = D[4k+3:4k], k=0 is LSD
//   DP_IN  in   NDIG     decimal point request per digit, active-high, live
//   LZ_EN  in   1        1 = blank leading zero digits
//   I      out  4        nibble of the current digit
//   AN     out  NDIG     anode enables, active-low, at most one bit low
//   DP     out  1        decimal point for the current digit, active-low
//   FRAME  out  1        one-clock pulse after the last slot wraps to slot 0

module display_scan_mux #(
    parameter int NDIG    = 4,
    parameter int DIV_W   = 16,
    parameter int DIV_MAX = 49999
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [4*NDIG-1:0] D,
    input  logic [NDIG-1:0]   DP_IN,
    input  logic              LZ_EN,
    output logic [3:0]        I,
    output logic [NDIG-1:0]   AN,
    output logic              DP,
    output logic              FRAME
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(DIV_MAX);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    logic [DIV_W-1:0]  div;
    logic [IDX_W-1:0]  idx;
    logic [4*NDIG-1:0] shadow;
    logic [4*NDIG-1:0] pending;
    logic              pend;
    logic              frame_q;

    logic              tick;
    logic              wrap;

    // Slot boundary and frame boundary (last slot ending).
    assign tick = (div == DIV_TC);
    assign wrap = tick && (idx == IDX_LAST);

    // Refresh divider, digit index, double-buffered value and frame pulse.
    // When a load coincides with the wrap, the shadow takes the value that
    // was already pending and the fresh D stays pending for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            div     <= '0;
            idx     <= '0;
            shadow  <= '0;
            pending <= '0;
            pend    <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            if (tick) begin
                div <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
                div <= div + DIV_W'(1);
            end

            frame_q <= wrap;

            if (wrap && pend) begin
                shadow <= pending;
            end

            if (load) begin
                pending <= D;
                pend    <= 1'b1;
            end else if (wrap) begin
                pend <= 1'b0;
            end
        end
    end

    logic [NDIG-1:0] zero_from;
    logic            run_zero;
    logic [3:0]      nibble;
    logic            dp_sel;
    logic            zero_sel;
    logic            blank;

    // zero_from[k] is set when nibbles k..NDIG-1 of the shadow are all zero,
    // i.e. digit k would be a leading zero. The index mux is written as a
    // compare loop so no variable part-select of the shadow is needed.
    always_comb begin
        zero_from = '0;
        run_zero  = 1'b1;
        nibble    = 4'h0;
        dp_sel    = 1'b0;
        zero_sel  = 1'b0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            run_zero     = run_zero & (shadow[4*k +: 4] == 4'h0);
            zero_from[k] = run_zero;
        end
        for (int k = 0; k < NDIG; k++) begin
            if (idx == IDX_W'(k)) begin
                nibble   = shadow[4*k +: 4];
                dp_sel   = DP_IN[k];
                zero_sel = zero_from[k];
            end
        end
    end

    // Digit 0 is never blanked so an all-zero value still shows "0".
    assign blank = LZ_EN && (idx != '0) && zero_sel;

    // A blanked slot keeps I driven but turns every anode and the DP off.
    always_comb begin
        AN = '1;
        for (int k = 0; k < NDIG; k++) begin
            if (idx == IDX_W'(k) && !blank) begin
                AN[k] = 1'b0;
            end
        end
    end

    assign I     = nibble;
    assign DP    = blank ? 1'b1 : ~dp_sel;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux
//
// Purpose:
//   Self-checking bench for display_scan_mux with NDIG=4, DIV_MAX=3
//   (4 clocks per slot, 16 clocks per frame). A reference model tracks the
//   number of clocks since reset and derives slot/frame position from it
//   arithmetically, plus the displayed/pending values and pend flag.
//   Directed scenarios are followed by a randomized run.
//
// Ports: none (top-level bench).

module tb_display_scan_mux;

    localparam int NDIG    = 4;
    localparam int DIV_W   = 16;
    localparam int DIV_MAX = 3;
    localparam int SLOT    = DIV_MAX + 1;
    localparam int FRAME_N = SLOT * NDIG;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] D;
    logic [3:0]  DP_IN;
    logic        LZ_EN;
    logic [3:0]  I;
    logic [3:0]  AN;
    logic        DP;
    logic        FRAME;

    int errors;
    int checks;

    // Reference model state.
    int          n_clk;
    logic [15:0] m_shadow;
    logic [15:0] m_pending;
    logic        m_pend;
    logic        m_frame;
    logic        m_valid;

    display_scan_mux #(
        .NDIG    (NDIG),
        .DIV_W   (DIV_W),
        .DIV_MAX (DIV_MAX)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .D     (D),
        .DP_IN (DP_IN),
        .LZ_EN (LZ_EN),
        .I     (I),
        .AN    (AN),
        .DP    (DP),
        .FRAME (FRAME)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare all outputs against what the model predicts for the current
    // clock position and the live DP_IN/LZ_EN inputs.
    task automatic checkOutput(input string tag);
        int          slot;
        logic [15:0] upper;
        logic        blank;
        logic [3:0]  exp_i;
        logic [3:0]  exp_an;
        logic        exp_dp;
        if (!m_valid) return;
        slot   = (n_clk / SLOT) % NDIG;
        upper  = m_shadow >> (4 * slot);
        blank  = LZ_EN && (slot != 0) && (upper == 16'h0);
        exp_i  = upper[3:0];
        exp_an = blank ? 4'hF : ~(4'b0001 << slot);
        exp_dp = blank ? 1'b1 : ~DP_IN[slot];

        checks++;
        assert (I === exp_i) else begin
            errors++;
            $error("[TB] FAIL %s I n=%0d actual=%h expected=%h", tag, n_clk, I, exp_i);
        end
        checks++;
        assert (AN === exp_an) else begin
            errors++;
            $error("[TB] FAIL %s AN n=%0d actual=%b expected=%b", tag, n_clk, AN, exp_an);
        end
        checks++;
        assert (DP === exp_dp) else begin
            errors++;
            $error("[TB] FAIL %s DP n=%0d actual=%b expected=%b", tag, n_clk, DP, exp_dp);
        end
        checks++;
        assert (FRAME === m_frame) else begin
            errors++;
            $error("[TB] FAIL %s FRAME n=%0d actual=%b expected=%b", tag, n_clk, FRAME, m_frame);
        end
    endtask

    // Drive one clock's worth of inputs, check the settled outputs, then
    // clock the DUT and advance the model by the same edge.
    task automatic applyStimulus(input string tag, input logic r, input logic ld,
                                 input logic [15:0] d, input logic [3:0] dp,
                                 input logic lz);
        logic wrap;
        rst   = r;
        load  = ld;
        D     = d;
        DP_IN = dp;
        LZ_EN = lz;
        #1;
        checkOutput(tag);
        @(posedge clk);
        if (r) begin
            n_clk     = 0;
            m_shadow  = 16'h0;
            m_pending = 16'h0;
            m_pend    = 1'b0;
            m_frame   = 1'b0;
            m_valid   = 1'b1;
        end else if (m_valid) begin
            wrap    = ((n_clk % FRAME_N) == FRAME_N - 1);
            m_frame = wrap;
            if (wrap && m_pend) m_shadow = m_pending;
            if (ld) begin
                m_pending = d;
                m_pend    = 1'b1;
            end else if (wrap) begin
                m_pend = 1'b0;
            end
            n_clk++;
        end
        @(negedge clk);
    endtask

    task automatic runIdle(input string tag, input int cycles, input logic lz);
        for (int c = 0; c < cycles; c++) applyStimulus(tag, 1'b0, 1'b0, 16'h0, 4'h0, lz);
    endtask

    // Idle until the model sits at the given position within the frame.
    task automatic gotoPhase(input string tag, input int phase, input logic lz);
        for (int c = 0; c < FRAME_N && (n_clk % FRAME_N) != phase; c++)
            applyStimulus(tag, 1'b0, 1'b0, 16'h0, 4'h0, lz);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        n_clk   = 0;
        m_valid = 1'b0;
        m_frame = 1'b0;
        rst = 1'b1; load = 1'b0; D = '0; DP_IN = '0; LZ_EN = 1'b0;
        @(negedge clk);

        // Reset and idle scan.
        applyStimulus("reset", 1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        applyStimulus("reset", 1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        runIdle("reset_idle", 4, 1'b0);

        // Load in slot 2, then two frames: zeros first, then 1234.
        gotoPhase("scan", 2 * SLOT, 1'b0);
        applyStimulus("scan_load", 1'b0, 1'b1, 16'h1234, 4'h0, 1'b0);
        runIdle("scan", 2 * FRAME_N, 1'b0);

        // Two loads in one frame: only the last should appear.
        gotoPhase("tear", 3, 1'b0);
        applyStimulus("tear_load1", 1'b0, 1'b1, 16'hABCD, 4'h0, 1'b0);
        runIdle("tear", 5, 1'b0);
        applyStimulus("tear_load2", 1'b0, 1'b1, 16'h5678, 4'h0, 1'b0);
        runIdle("tear", FRAME_N + 4, 1'b0);

        // Decimal points are live per digit.
        for (int k = 0; k < FRAME_N; k++)
            applyStimulus("dp", 1'b0, 1'b0, 16'h0, 4'b0101, 1'b0);

        // Leading-zero blanking.
        applyStimulus("lz_load", 1'b0, 1'b1, 16'h0050, 4'h0, 1'b0);
        gotoPhase("lz", 0, 1'b0);
        runIdle("lz_on", FRAME_N, 1'b1);
        for (int k = 0; k < FRAME_N; k++)
            applyStimulus("lz_dp", 1'b0, 1'b0, 16'h0, 4'hF, 1'b1);
        applyStimulus("lz_zero", 1'b0, 1'b1, 16'h0000, 4'h0, 1'b1);
        gotoPhase("lz", 0, 1'b1);
        runIdle("lz_zero", FRAME_N, 1'b1);
        runIdle("lz_off", FRAME_N, 1'b0);

        // Load on the wrap edge while another value is pending.
        gotoPhase("coll", 4, 1'b0);
        applyStimulus("coll_load1", 1'b0, 1'b1, 16'h2222, 4'h0, 1'b0);
        gotoPhase("coll", FRAME_N - 1, 1'b0);
        applyStimulus("coll_load2", 1'b0, 1'b1, 16'h1111, 4'h0, 1'b0);
        runIdle("coll", 2 * FRAME_N, 1'b0);

        // Reset in slot 2 with a load pending: nothing transfers afterwards.
        applyStimulus("rstmid_load", 1'b0, 1'b1, 16'h9999, 4'h0, 1'b0);
        gotoPhase("rstmid", 2 * SLOT + 1, 1'b0);
        applyStimulus("rstmid", 1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        runIdle("rstmid", FRAME_N + 4, 1'b0);

        // Randomized run.
        for (int c = 0; c < 400; c++) begin
            applyStimulus("rand", ($urandom_range(63) == 0),
                          ($urandom_range(7) == 0),
                          16'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
